// File: rtl/tcdm_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcdm_bank_arbiter: shares one TCDM bank between a local port (priority,  |
// | bounded by a stall counter) and round-robin remote ports.                |
// | Optional perf counters: define TCDM_BANK_ARB_PERF_EN.      Rev 1.0        |
// +--------------------------------------------------------------------------+
module tcdm_bank_arbiter #(
  parameter int NumReq       = 4,
  parameter int DataWidth    = 32,
  parameter int AddrMemWidth = 8,
  parameter int MaxStall     = 7,
  parameter int WriteRespOn  = 0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumReq-1:0]                      req_i,
  input  logic [NumReq-1:0][AddrMemWidth-1:0]    addr_i,
  input  logic [NumReq-1:0]                      wen_i,
  input  logic [NumReq-1:0][DataWidth-1:0]       wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]     be_i,
  output logic [NumReq-1:0]                      gnt_o,
  output logic [NumReq-1:0]                      vld_o,
  output logic [DataWidth-1:0]                   rdata_o,
  output logic                                   mem_req_o,
  output logic [AddrMemWidth-1:0]                mem_addr_o,
  output logic                                   mem_wen_o,
  output logic [DataWidth-1:0]                   mem_wdata_o,
  output logic [DataWidth/8-1:0]                 mem_be_o,
  input  logic [DataWidth-1:0]                   mem_rdata_i
`ifdef TCDM_BANK_ARB_PERF_EN
  ,
  output logic [31:0]                            conflict_cnt_o,
  output logic [31:0]                            stall_evt_cnt_o
`endif
);

  localparam int              IdxW      = (NumReq > 2) ? $clog2(NumReq) : 1;
  localparam logic [7:0]      MaxStallC = 8'(MaxStall);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumReq - 1);

  if (NumReq < 2 || MaxStall < 1 || MaxStall > 255) begin : g_bad_cfg
    $fatal(1, "tcdm_bank_arbiter: illegal configuration");
  end

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      stall_cnt_q, stall_cnt_d;
  logic            resp_vld_q, resp_vld_d;
  logic [IdxW-1:0] resp_idx_q, resp_idx_d;

  logic            remote_pend;
  logic            stall_hit;
  logic            local_gnt;
  logic            remote_gnt;
  logic [IdxW-1:0] gnt_idx;
  int              cand;

  always_comb begin
    remote_pend = |req_i[NumReq-1:1];
    stall_hit   = remote_pend && (stall_cnt_q == MaxStallC);
    local_gnt   = 1'b0;
    remote_gnt  = 1'b0;
    gnt_idx     = '0;
    cand        = 0;
    if (req_i[0] && !stall_hit) begin
      local_gnt = 1'b1;
    end else if (remote_pend) begin
      // Scan the remote ports starting at rr_ptr, wrapping NumReq-1 -> 1.
      for (int i = 0; i < NumReq - 1; i++) begin
        cand = int'(rr_ptr_q) + i;
        if (cand > NumReq - 1) cand = cand - (NumReq - 1);
        if (!remote_gnt && req_i[cand[IdxW-1:0]]) begin
          remote_gnt = 1'b1;
          gnt_idx    = cand[IdxW-1:0];
        end
      end
    end

    gnt_o = '0;
    if (local_gnt || remote_gnt) gnt_o[gnt_idx] = 1'b1;

    mem_req_o   = local_gnt || remote_gnt;
    mem_addr_o  = addr_i[gnt_idx];
    mem_wen_o   = wen_i[gnt_idx];
    mem_wdata_o = wdata_i[gnt_idx];
    mem_be_o    = be_i[gnt_idx];

    rr_ptr_d = rr_ptr_q;
    if (remote_gnt) rr_ptr_d = (gnt_idx == LastIdx) ? IdxW'(1) : gnt_idx + IdxW'(1);

    stall_cnt_d = '0;
    if (local_gnt && remote_pend)
      stall_cnt_d = (stall_cnt_q == MaxStallC) ? stall_cnt_q : stall_cnt_q + 8'd1;

    resp_vld_d = mem_req_o && (!mem_wen_o || (WriteRespOn != 0));
    resp_idx_d = gnt_idx;

    vld_o = '0;
    if (resp_vld_q) vld_o[resp_idx_q] = 1'b1;
    rdata_o = resp_vld_q ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= IdxW'(1);
      stall_cnt_q <= '0;
      resp_vld_q  <= 1'b0;
      resp_idx_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      resp_vld_q  <= resp_vld_d;
      resp_idx_q  <= resp_idx_d;
    end
  end

`ifdef TCDM_BANK_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] stall_evt_cnt_q, stall_evt_cnt_d;

  // A stall event is the override beating a pending local request.
  always_comb begin
    conflict_cnt_d  = conflict_cnt_q;
    stall_evt_cnt_d = stall_evt_cnt_q;
    if (($countones(req_i) > 1) && (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    if (req_i[0] && stall_hit && (stall_evt_cnt_q != '1))
      stall_evt_cnt_d = stall_evt_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q  <= '0;
      stall_evt_cnt_q <= '0;
    end else begin
      conflict_cnt_q  <= conflict_cnt_d;
      stall_evt_cnt_q <= stall_evt_cnt_d;
    end
  end

  assign conflict_cnt_o  = conflict_cnt_q;
  assign stall_evt_cnt_o = stall_evt_cnt_q;
`else
`endif

endmodule
`default_nettype wire
